// File: rtl/cmul_pkg.sv
// Shared widths, FSM state type, saturation constants and MAC latency for the
// complex-multiply MAC sequencer.
package cmul_pkg;

  localparam int unsigned W_IN         = 18;
  localparam int unsigned W_PROD       = 36;
  localparam int unsigned W_ACC        = 48;
  localparam int unsigned CMUL_MAC_LAT = 2;

  localparam logic signed [W_IN-1:0] S18_MAX = 18'sh1FFFF;  // +131071
  localparam logic signed [W_IN-1:0] S18_MIN = 18'sh20000;  // -131072

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_P0,
    ST_P1,
    ST_P2,
    ST_P3
  } cmul_state_e;

  // -(-2^17) is not representable in 18 bits, so it clamps to +2^17-1
  function automatic logic signed [W_IN-1:0] sat_neg(input logic signed [W_IN-1:0] v);
    if (v == S18_MIN) return S18_MAX;
    return -v;
  endfunction

endpackage

// File: rtl/cmul_out_fifo.sv
// Two-entry synchronous result FIFO with occupancy count; async active-low reset.
module cmul_out_fifo
  import cmul_pkg::*;
#(
  parameter int unsigned W = 2 * W_ACC
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         wr_do;
  logic         rd_do;

  assign rd_do = rd_en & (count_q != 2'd0);
  assign wr_do = wr_en & ((count_q != 2'd2) | rd_do);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (wr_do) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (rd_do) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, wr_do} - {1'b0, rd_do};
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/cmul_mac_sequencer.sv
// Schedules one complex multiply (a+jb)(c+jd) as four real products on a shared MAC.
// Optional round-half-up addend enabled by defining CMUL_ROUND_EN.
module cmul_mac_sequencer
  import cmul_pkg::*;
#(
  parameter int unsigned RND_SHIFT = 17,
  parameter int unsigned MAC_LAT   = CMUL_MAC_LAT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_valid,
  output logic                    o_in_ready,
  input  logic signed [W_IN-1:0]  i_s18_re,
  input  logic signed [W_IN-1:0]  i_s18_im,
  input  logic signed [W_IN-1:0]  i_s18_wre,
  input  logic signed [W_IN-1:0]  i_s18_wim,
  output logic                    o_valid,
  input  logic                    i_out_ready,
  output logic signed [W_ACC-1:0] o_s48_re,
  output logic signed [W_ACC-1:0] o_s48_im,
  output logic                    o_sat,
  output logic                    o_sel,
  output logic signed [W_IN-1:0]  o_s18_X,
  output logic signed [W_IN-1:0]  o_s18_Y,
  output logic signed [W_ACC-1:0] o_s48_C,
  input  logic signed [W_ACC-1:0] i_s48_XY_plus_C
);

  localparam int unsigned TAG_RE = MAC_LAT;
  localparam int unsigned TAG_IM = MAC_LAT + 2;

  if (MAC_LAT != CMUL_MAC_LAT) begin : g_bad_mac_lat
    $error("cmul_mac_sequencer: MAC_LAT must be %0d", CMUL_MAC_LAT);
  end
  if (RND_SHIFT < 1 || RND_SHIFT > 46) begin : g_bad_rnd_shift
    $error("cmul_mac_sequencer: RND_SHIFT out of range 1..46");
  end
  if (W_ACC < W_PROD) begin : g_bad_acc_width
    $error("cmul_mac_sequencer: accumulator narrower than product");
  end

  cmul_state_e             state_q, state_d;
  logic signed [W_IN-1:0]  a_q, b_q, nb_q, c_q, d_q;
  logic                    sel_q;
  logic                    sat_q;
  logic                    rdy_en_q;
  logic [TAG_IM:0]         tag_q;
  logic signed [W_ACC-1:0] re_q;
  logic [1:0]              in_flight_q;
  logic [1:0]              fifo_count;
  logic [2*W_ACC-1:0]      fifo_rdata;
  logic                    accept;
  logic                    pop;
  logic                    fifo_wr;
  logic [2:0]              occ;

  assign o_valid = (fifo_count != 2'd0);
  assign pop     = o_valid & i_out_ready;
  assign occ     = {1'b0, in_flight_q} + {1'b0, fifo_count} - {2'b0, pop};
  // rdy_en_q holds ready low until the first clock after reset release
  assign o_in_ready = rdy_en_q & ((state_q == ST_IDLE) | (state_q == ST_P3)) & (occ < 3'd2);
  assign accept  = i_valid & o_in_ready;
  assign fifo_wr = tag_q[TAG_IM];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_P0;
      ST_P0:   state_d = ST_P1;
      ST_P1:   state_d = ST_P2;
      ST_P2:   state_d = ST_P3;
      ST_P3:   state_d = accept ? ST_P0 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_s18_X = '0;
    o_s18_Y = '0;
    case (state_q)
      ST_P0: begin o_s18_X = a_q;  o_s18_Y = c_q; end
      ST_P1: begin o_s18_X = nb_q; o_s18_Y = d_q; end
      ST_P2: begin o_s18_X = a_q;  o_s18_Y = d_q; end
      ST_P3: begin o_s18_X = b_q;  o_s18_Y = c_q; end
      default: ;
    endcase
  end

  // tag bit k is set k+1 cycles after a P0 issue; results are picked off by age, not state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      nb_q        <= '0;
      c_q         <= '0;
      d_q         <= '0;
      sel_q       <= 1'b0;
      sat_q       <= 1'b0;
      rdy_en_q    <= 1'b0;
      tag_q       <= '0;
      re_q        <= '0;
      in_flight_q <= '0;
    end else begin
      state_q     <= state_d;
      rdy_en_q    <= 1'b1;
      sel_q       <= (state_q == ST_P0) | (state_q == ST_P2);
      tag_q       <= {tag_q[TAG_IM-1:0], state_q == ST_P0};
      in_flight_q <= in_flight_q + {1'b0, accept} - {1'b0, fifo_wr};
      if (tag_q[TAG_RE]) re_q <= i_s48_XY_plus_C;
      if (accept) begin
        a_q  <= i_s18_re;
        b_q  <= i_s18_im;
        nb_q <= sat_neg(i_s18_im);
        c_q  <= i_s18_wre;
        d_q  <= i_s18_wim;
        if (i_s18_im == S18_MIN) sat_q <= 1'b1;
      end
    end
  end

  assign o_sel = sel_q;
  assign o_sat = sat_q;

`ifdef CMUL_ROUND_EN
  localparam logic [W_ACC-1:0] RND_C = {{(W_ACC-1){1'b0}}, 1'b1} << (RND_SHIFT - 1);
  assign o_s48_C = sel_q ? RND_C : '0;
`else
  assign o_s48_C = '0;
`endif

  cmul_out_fifo #(
    .W (2 * W_ACC)
  ) u_out_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (fifo_wr),
    .wr_data ({re_q, i_s48_XY_plus_C}),
    .rd_en   (pop),
    .rd_data (fifo_rdata),
    .count   (fifo_count)
  );

  assign o_s48_re = fifo_rdata[2*W_ACC-1:W_ACC];
  assign o_s48_im = fifo_rdata[W_ACC-1:0];

endmodule

// File: tb/tb_cmul_mac_sequencer.sv
// Scoreboard bench for cmul_mac_sequencer with a behavioural MAC and reference model.
`timescale 1ns/1ps
module tb_cmul_mac_sequencer;

  localparam int RS = 17;
`ifdef CMUL_ROUND_EN
  localparam longint RND = 64'sd1 <<< (RS - 1);
`else
  localparam longint RND = 64'sd0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               i_valid = 1'b0;
  logic               o_in_ready;
  logic signed [17:0] i_s18_re = '0, i_s18_im = '0, i_s18_wre = '0, i_s18_wim = '0;
  logic               o_valid;
  logic               i_out_ready = 1'b1;
  logic signed [47:0] o_s48_re, o_s48_im;
  logic               o_sat, o_sel;
  logic signed [17:0] o_s18_X, o_s18_Y;
  logic signed [47:0] o_s48_C;
  logic signed [47:0] i_s48_XY_plus_C;

  cmul_mac_sequencer #(.RND_SHIFT(RS)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_in_ready(o_in_ready),
    .i_s18_re(i_s18_re), .i_s18_im(i_s18_im), .i_s18_wre(i_s18_wre), .i_s18_wim(i_s18_wim),
    .o_valid(o_valid), .i_out_ready(i_out_ready), .o_s48_re(o_s48_re), .o_s48_im(o_s48_im),
    .o_sat(o_sat), .o_sel(o_sel), .o_s18_X(o_s18_X), .o_s18_Y(o_s18_Y), .o_s48_C(o_s48_C),
    .i_s48_XY_plus_C(i_s48_XY_plus_C)
  );

  always #5 clk = ~clk;

  // MAC: operands registered, then P = X*Y + C when sel, else P += X*Y; never reset
  logic signed [17:0] mac_x1 = '0, mac_y1 = '0;
  logic signed [47:0] mac_p = '0;
  always @(posedge clk) begin
    if (o_sel) mac_p <= 48'(longint'(mac_x1) * longint'(mac_y1) + longint'(o_s48_C));
    else       mac_p <= 48'(longint'(mac_p) + longint'(mac_x1) * longint'(mac_y1));
    mac_x1 <= o_s18_X;
    mac_y1 <= o_s18_Y;
  end
  assign i_s48_XY_plus_C = mac_p;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int unsigned rdy_mode = 1;  // 0 low, 1 high, 2 random
  always @(negedge clk) begin
    case (rdy_mode)
      0:       i_out_ready = 1'b0;
      1:       i_out_ready = 1'b1;
      default: i_out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  typedef struct packed { longint re; longint im; } exp_t;
  exp_t exp_q[$];
  bit   sat_model = 1'b0;

  int unsigned n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input longint got, input longint expv);
    n_chk++;
    if (got == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, expv);
  endtask

  task automatic push_exp(input int a, input int b, input int c, input int d);
    longint nb;
    exp_t   e;
    nb = (b == -131072) ? 64'sd131071 : -longint'(b);
    e.re = longint'(a) * c + nb * d + RND;
    e.im = longint'(a) * d + longint'(b) * c + RND;
    exp_q.push_back(e);
    if (b == -131072) sat_model = 1'b1;
  endtask

  task automatic send(input int a, input int b, input int c, input int d,
                      input int unsigned max_wait, output bit ok, output int unsigned acc_cyc);
    ok = 1'b0;
    acc_cyc = 0;
    @(negedge clk);
    i_valid   = 1'b1;
    i_s18_re  = 18'(a);
    i_s18_im  = 18'(b);
    i_s18_wre = 18'(c);
    i_s18_wim = 18'(d);
    for (int unsigned w = 0; w < max_wait && !ok; w++) begin
      #1;
      if (o_in_ready) begin
        ok = 1'b1;
        acc_cyc = cyc;
        push_exp(a, b, c, d);
      end else begin
        @(negedge clk);
      end
    end
    if (ok) @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, longint'(o_valid), 0);
    chk({tag, "_in_ready"}, longint'(o_in_ready), 0);
    chk({tag, "_sel"}, longint'(o_sel), 0);
    chk({tag, "_sat"}, longint'(o_sat), 0);
    chk({tag, "_X"}, longint'(o_s18_X), 0);
    chk({tag, "_Y"}, longint'(o_s18_Y), 0);
    chk({tag, "_C"}, longint'(o_s48_C), 0);
    chk({tag, "_re"}, longint'(o_s48_re), 0);
    chk({tag, "_im"}, longint'(o_s48_im), 0);
  endtask

  task automatic drain(input string name);
    int unsigned n;
    n = 0;
    while ((exp_q.size() != 0 || o_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, longint'(exp_q.size()), 0);
  endtask

  function automatic int rand18();
    case ($urandom_range(0, 5))
      0:       return -131072;
      1:       return 131071;
      2:       return 0;
      3:       return -1;
      default: return int'($urandom_range(0, 262143)) - 131072;
    endcase
  endfunction

  // Monitor: pops the scoreboard whenever a result is handed off
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (o_valid && i_out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_output", longint'(o_valid), 0);
        else begin
          e = exp_q.pop_front();
          chk("result_re", longint'(o_s48_re), e.re);
          chk("result_im", longint'(o_s48_im), e.im);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    int unsigned acc, prev_acc, n, naccepted;

    repeat (3) @(negedge clk);
    #1 chk_reset_outputs("reset");
    rst_n = 1'b1;
    #1 chk("ready_at_release", longint'(o_in_ready), 0);
    @(negedge clk);
    #1 chk("ready_after_release", longint'(o_in_ready), 1);

    // Case 1: latency and directed values
    send(3, 4, 5, 6, 10, ok, acc);
    chk("case1_accept", longint'(ok), 1);
    n = 0;
    while (!o_valid && n < 30) begin @(negedge clk); n++; end
    chk("case1_latency", longint'(cyc) - longint'(acc) - 1, 6);
`ifdef CMUL_ROUND_EN
    chk("case1_re", longint'(o_s48_re), 65527);
    chk("case1_im", longint'(o_s48_im), 65574);
`else
    chk("case1_re", longint'(o_s48_re), -9);
    chk("case1_im", longint'(o_s48_im), 38);
`endif
    chk("case1_sat", longint'(o_sat), 0);
    drain("case1_drain");

    // Back-to-back: one accept every 4 cycles
    prev_acc = 0;
    for (int i = 0; i < 8; i++) begin
      send(rand18(), rand18(), rand18(), rand18(), 20, ok, acc);
      chk("b2b_accept", longint'(ok), 1);
      if (i > 0) chk("b2b_spacing", longint'(acc) - longint'(prev_acc), 4);
      prev_acc = acc;
    end
    drain("b2b_drain");

    // Backpressure: only two fit in flight + FIFO
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    naccepted = 0;
    for (int i = 0; i < 3; i++) begin
      send(rand18(), rand18(), rand18(), rand18(), 16, ok, acc);
      if (ok) naccepted++;
    end
    chk("bp_accepted", longint'(naccepted), 2);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1 if (o_in_ready) n++;
    end
    chk("bp_ready_held_low", longint'(n), 0);
    chk("bp_valid_held", longint'(o_valid), 1);
    rdy_mode = 1;
    send(rand18(), rand18(), rand18(), rand18(), 30, ok, acc);
    chk("bp_resume_accept", longint'(ok), 1);
    drain("bp_drain");

    // Saturating negation
    send(0, -131072, 0, 1, 20, ok, acc);
    n = 0;
    while (!o_valid && n < 30) begin @(negedge clk); n++; end
    chk("sat_re", longint'(o_s48_re), 131071 + RND);
    chk("sat_im", longint'(o_s48_im), RND);
    chk("sat_flag", longint'(o_sat), 1);
    drain("sat_drain");

    // Random traffic with random downstream stalls
    rdy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      send(rand18(), rand18(), rand18(), rand18(), 60, ok, acc);
      chk("rand_accept", longint'(ok), 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    rdy_mode = 1;
    drain("rand_drain");
    chk("sat_sticky", longint'(o_sat), longint'(sat_model));

    // Reset two cycles after an accept discards that operation
    send(rand18(), rand18(), rand18(), rand18(), 20, ok, acc);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    sat_model = 1'b0;
    #1 chk_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1 if (o_valid) n++;
    end
    chk("midreset_no_valid", longint'(n), 0);
    send(-1234, 5678, 131071, -131072, 20, ok, acc);
    chk("midreset_accept", longint'(ok), 1);
    drain("midreset_drain");
    chk("midreset_sat", longint'(o_sat), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
